store_write_buffer: RTL and testbench

//  Posted-store buffer between the pipeline CPU data port (MEM stage) and the data RAM.
//  - Absorbs stores into a small FIFO and drains them to RAM in cycles where the CPU does not read.
//  - Forwards buffered bytes to loads, merged per byte lane.
//  - Raises a stall request to HazardControl only when full.

---
 rtl/store_write_buffer_pkg.sv | 35 +++
 rtl/store_write_buffer_if.sv | 33 +++
 rtl/store_write_buffer_fwd_merge.sv | 30 +++
 rtl/store_write_buffer.sv | 99 +++++++++
 tb/tb_store_write_buffer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/store_write_buffer_pkg.sv
// Shared types and sizing for the posted-store write buffer.
// Entry layout: word address, byte-lane mask, lane-aligned data.
package store_write_buffer_pkg;

   localparam int WB_DEPTH   = 4;
   localparam int WB_PTR_W   = $clog2(WB_DEPTH);
   localparam int WB_MASK_W  = 4;
   localparam int MEM_ADDR_W = 32;
   localparam int REG_DATA_W = 32;
   localparam int WADDR_W    = MEM_ADDR_W - 2;

   typedef logic [WB_PTR_W-1:0] wb_ptr_t;
   typedef logic [WB_PTR_W:0]   wb_cnt_t;

   typedef struct packed {
      logic [WADDR_W-1:0]    waddr;
      logic [WB_MASK_W-1:0]  mask;
      logic [REG_DATA_W-1:0] data;
   } wb_entry_t;

   // Overwrite only the byte lanes selected by mask.
   function automatic logic [REG_DATA_W-1:0] merge_lanes(
      input logic [REG_DATA_W-1:0] old_data,
      input logic [REG_DATA_W-1:0] new_data,
      input logic [WB_MASK_W-1:0]  mask
   );
      logic [REG_DATA_W-1:0] res;
      res = old_data;
      for (int l = 0; l < WB_MASK_W; l++) begin
         if (mask[l]) res[8*l +: 8] = new_data[8*l +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/store_write_buffer_if.sv
// CPU data port and data-RAM port of the write buffer, bundled as one interface.
// The buffer takes the slave view; the CPU/RAM environment takes the master view.
interface store_write_buffer_if;
   import store_write_buffer_pkg::*;

   logic [MEM_ADDR_W-1:0] cpu_addr_i;
   logic [WB_MASK_W-1:0]  cpu_byte_slct_i;
   logic [REG_DATA_W-1:0] cpu_data_i;
   logic                  cpu_we_i;
   logic                  cpu_re_i;
   logic [REG_DATA_W-1:0] cpu_data_o;
   logic                  stall_req_o;
   logic                  empty_o;
   logic [MEM_ADDR_W-1:0] mem_addr_o;
   logic [WB_MASK_W-1:0]  mem_byte_slct_o;
   logic [REG_DATA_W-1:0] mem_data_o;
   logic                  mem_we_o;
   logic                  mem_re_o;
   logic [REG_DATA_W-1:0] mem_data_i;

   modport slave (
      input  cpu_addr_i, cpu_byte_slct_i, cpu_data_i, cpu_we_i, cpu_re_i, mem_data_i,
      output cpu_data_o, stall_req_o, empty_o,
      output mem_addr_o, mem_byte_slct_o, mem_data_o, mem_we_o, mem_re_o
   );

   modport master (
      output cpu_addr_i, cpu_byte_slct_i, cpu_data_i, cpu_we_i, cpu_re_i, mem_data_i,
      input  cpu_data_o, stall_req_o, empty_o,
      input  mem_addr_o, mem_byte_slct_o, mem_data_o, mem_we_o, mem_re_o
   );

endinterface

// File: rtl/store_write_buffer_fwd_merge.sv
// Load forwarding: per byte lane, take the newest valid buffered byte for the
// looked-up word, otherwise the RAM byte.
module wb_fwd_merge
   import store_write_buffer_pkg::*;
(
   input  wb_entry_t             entries_i [WB_DEPTH],
   input  logic [WB_DEPTH-1:0]   valid_i,
   input  wb_ptr_t               head_i,
   input  wb_cnt_t               count_i,
   input  logic [WADDR_W-1:0]    waddr_i,
   input  logic [REG_DATA_W-1:0] mem_data_i,
   output logic [REG_DATA_W-1:0] data_o
);

   wb_ptr_t idx;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      data_o = mem_data_i;
      idx    = head_i;
      // Walk oldest to newest so that a younger matching byte overrides an older one.
      for (int k = 0; k < WB_DEPTH; k++) begin
         idx = head_i + wb_ptr_t'(k);
         if ((wb_cnt_t'(k) < count_i) && valid_i[idx] && (entries_i[idx].waddr == waddr_i)) begin
            data_o = merge_lanes(data_o, entries_i[idx].data, entries_i[idx].mask);
         end
      end
   end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-store buffer between the CPU MEM stage and the data RAM: circular FIFO
// with same-word coalescing, drain on non-load cycles and byte-lane load forwarding.
module store_write_buffer
   import store_write_buffer_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   store_write_buffer_if.slave bus
);

   wb_entry_t             entry_q [WB_DEPTH];
   logic [WB_DEPTH-1:0]   valid_q, valid_d;
   wb_ptr_t               head_q, head_d;
   wb_ptr_t               tail_q, tail_d;
   wb_cnt_t               count_q, count_d;

   logic [WADDR_W-1:0]    cpu_waddr;
   wb_ptr_t               newest;
   logic                  full;
   logic                  drain;
   logic                  coalesce;
   logic                  append;

   assign cpu_waddr = bus.cpu_addr_i[MEM_ADDR_W-1:2];
   assign newest    = tail_q - wb_ptr_t'(1);
   assign full      = (count_q == wb_cnt_t'(WB_DEPTH));
   assign drain     = (count_q != '0) && !bus.cpu_re_i;

   // Coalescing into the head entry while it drains would lose the new bytes.
   assign coalesce  = bus.cpu_we_i && (count_q != '0) && valid_q[newest]
                      && (entry_q[newest].waddr == cpu_waddr)
                      && ((count_q >= wb_cnt_t'(2)) || bus.cpu_re_i);
   assign append    = bus.cpu_we_i && !coalesce && !full;

   assign bus.stall_req_o     = bus.cpu_we_i && !coalesce && full;
   assign bus.empty_o         = (count_q == '0);
   assign bus.mem_we_o        = drain;
   assign bus.mem_re_o        = bus.cpu_re_i;
   assign bus.mem_addr_o      = drain ? {entry_q[head_q].waddr, 2'b00} : bus.cpu_addr_i;
   assign bus.mem_byte_slct_o = drain ? entry_q[head_q].mask : bus.cpu_byte_slct_i;
   assign bus.mem_data_o      = drain ? entry_q[head_q].data : bus.cpu_data_i;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      if (drain) begin
         head_d          = head_q + wb_ptr_t'(1);
         valid_d[head_q] = 1'b0;
      end
      if (append) begin
         tail_d          = tail_q + wb_ptr_t'(1);
         valid_d[tail_q] = 1'b1;
      end
      if (append && !drain) begin
         count_d = count_q + wb_cnt_t'(1);
      end else if (drain && !append) begin
         count_d = count_q - wb_cnt_t'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // NOTE: entry storage has no reset; valid_q and count_q gate every use of it.
   always_ff @(posedge clk) begin
      if (append) begin
         entry_q[tail_q] <= '{waddr: cpu_waddr, mask: bus.cpu_byte_slct_i, data: bus.cpu_data_i};
      end else if (coalesce) begin
         entry_q[newest].mask <= entry_q[newest].mask | bus.cpu_byte_slct_i;
         entry_q[newest].data <= merge_lanes(entry_q[newest].data, bus.cpu_data_i,
                                             bus.cpu_byte_slct_i);
      end
   end

   wb_fwd_merge u_fwd_merge (
      .entries_i  (entry_q),
      .valid_i    (valid_q),
      .head_i     (head_q),
      .count_i    (count_q),
      .waddr_i    (cpu_waddr),
      .mem_data_i (bus.mem_data_i),
      .data_o     (bus.cpu_data_o)
   );

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios plus randomized
// traffic against a queue-based model of the buffer and a reference RAM image.
module tb_store_write_buffer;
   import store_write_buffer_pkg::*;

   logic clk;
   logic rst;

   store_write_buffer_if bus ();

   store_write_buffer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [29:0] waddr;
      logic [3:0]  mask;
      logic [31:0] data;
   } ref_entry_t;

   ref_entry_t  mq [$];
   logic [31:0] ram     [64];
   logic [31:0] ref_ram [64];

   int checks   = 0;
   int failures = 0;

   logic        last_we, last_stall, last_empty;
   logic [31:0] last_addr, last_data, last_load;
   logic [3:0]  last_slct;

   assign bus.mem_data_i = ram[bus.mem_addr_o[7:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // One CPU cycle: drive at negedge, check against the model, then let the RAM take any write.
   task automatic cycle(input logic we, input logic re, input logic [31:0] addr,
                        input logic [3:0] slct, input logic [31:0] data);
      logic [29:0] wa;
      logic        drn, coal, stl;
      logic [31:0] exp_load;
      logic        found;
      int          ma;
      @(negedge clk);
      bus.cpu_we_i        = we;
      bus.cpu_re_i        = re;
      bus.cpu_addr_i      = addr;
      bus.cpu_byte_slct_i = slct;
      bus.cpu_data_i      = data;
      #1;
      wa   = addr[31:2];
      drn  = (mq.size() > 0) && !re;
      coal = we && (mq.size() > 0) && (mq[mq.size()-1].waddr == wa) && ((mq.size() >= 2) || re);
      stl  = we && !coal && (mq.size() == WB_DEPTH);
      check("empty",  32'(bus.empty_o),     32'(mq.size() == 0));
      check("stall",  32'(bus.stall_req_o), 32'(stl));
      check("mem_we", 32'(bus.mem_we_o),    32'(drn));
      check("mem_re", 32'(bus.mem_re_o),    32'(re));
      if (drn) begin
         check("drain_addr", bus.mem_addr_o,          {mq[0].waddr, 2'b00});
         check("drain_slct", 32'(bus.mem_byte_slct_o), 32'(mq[0].mask));
         check("drain_data", bus.mem_data_o,          mq[0].data);
      end
      if (re) begin
         exp_load = ref_ram[addr[7:2]];
         for (int l = 0; l < 4; l++) begin
            found = 1'b0;
            for (int j = mq.size() - 1; j >= 0; j--) begin
               if (!found && mq[j].waddr == wa && mq[j].mask[l]) begin
                  exp_load[8*l +: 8] = mq[j].data[8*l +: 8];
                  found = 1'b1;
               end
            end
         end
         check("load_data", bus.cpu_data_o, exp_load);
      end
      last_we    = bus.mem_we_o;
      last_stall = bus.stall_req_o;
      last_empty = bus.empty_o;
      last_addr  = bus.mem_addr_o;
      last_data  = bus.mem_data_o;
      last_slct  = bus.mem_byte_slct_o;
      last_load  = bus.cpu_data_o;
      if (coal) begin
         for (int l = 0; l < 4; l++) begin
            if (slct[l]) mq[mq.size()-1].data[8*l +: 8] = data[8*l +: 8];
         end
         mq[mq.size()-1].mask = mq[mq.size()-1].mask | slct;
      end else if (we && !stl) begin
         mq.push_back('{waddr: wa, mask: slct, data: data});
      end
      if (drn) begin
         ma = int'(mq[0].waddr[5:0]);
         for (int l = 0; l < 4; l++) begin
            if (mq[0].mask[l]) ref_ram[ma][8*l +: 8] = mq[0].data[8*l +: 8];
         end
         void'(mq.pop_front());
      end
      #3;
      if (bus.mem_we_o) begin
         for (int l = 0; l < 4; l++) begin
            if (bus.mem_byte_slct_o[l]) ram[bus.mem_addr_o[7:2]][8*l +: 8] = bus.mem_data_o[8*l +: 8];
         end
      end
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   task automatic drain_all(input string tag);
      int n;
      n = 0;
      while (n < 20) begin
         idle();
         if (last_empty) break;
         n++;
      end
      check(tag, 32'(last_empty), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] saved;
      rst                 = 1'b0;
      bus.cpu_we_i        = 1'b0;
      bus.cpu_re_i        = 1'b0;
      bus.cpu_addr_i      = '0;
      bus.cpu_byte_slct_i = '0;
      bus.cpu_data_i      = '0;
      for (int i = 0; i < 64; i++) ram[i] = $urandom;
      ram[8] = 32'h1122_3344;
      for (int i = 0; i < 64; i++) ref_ram[i] = ram[i];

      // Reset state with idle inputs
      @(negedge clk);
      #1;
      check("rst_empty",  32'(bus.empty_o),     32'd1);
      check("rst_mem_we", 32'(bus.mem_we_o),    32'd0);
      check("rst_stall",  32'(bus.stall_req_o), 32'd0);
      check("rst_mem_re", 32'(bus.mem_re_o),    32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Single word store drains the next cycle
      cycle(1'b1, 1'b0, 32'h10, 4'hF, 32'hDEAD_BEEF);
      idle();
      check("t2_we",   32'(last_we), 32'd1);
      check("t2_addr", last_addr,    32'h10);
      check("t2_data", last_data,    32'hDEAD_BEEF);
      idle();
      check("t2_empty", 32'(last_empty), 32'd1);

      // Reset while draining with two entries pending
      cycle(1'b1, 1'b1, 32'h44, 4'hF, 32'h0101_0101);
      cycle(1'b1, 1'b1, 32'h48, 4'hF, 32'h0202_0202);
      saved = ram[17];
      @(negedge clk);
      bus.cpu_we_i = 1'b0;
      bus.cpu_re_i = 1'b0;
      #1;
      check("t1_pre_we", 32'(bus.mem_we_o), 32'd1);
      #1 rst = 1'b0;
      #1;
      check("t1_we",    32'(bus.mem_we_o), 32'd0);
      check("t1_empty", 32'(bus.empty_o),  32'd1);
      @(negedge clk);
      rst = 1'b1;
      mq.delete();
      repeat (3) idle();
      check("t1_ram44", ram[17], saved);
      check("t1_ram48", ram[18], ref_ram[18]);

      // Forward a buffered byte merged with RAM
      cycle(1'b1, 1'b0, 32'h20, 4'b0001, 32'h0000_00AA);
      cycle(1'b0, 1'b1, 32'h20, 4'hF, 32'h0);
      check("t3_load", last_load, 32'h1122_33AA);
      drain_all("t3_drain_bound");

      // Coalesce two halfword stores held off by a load
      cycle(1'b1, 1'b1, 32'h30, 4'b0011, 32'h0000_BEEF);
      check("t4_no_drain", 32'(last_we), 32'd0);
      cycle(1'b1, 1'b1, 32'h30, 4'b1100, 32'hCAFE_0000);
      idle();
      check("t4_we",   32'(last_we),   32'd1);
      check("t4_data", last_data,      32'hCAFE_BEEF);
      check("t4_slct", 32'(last_slct), 32'hF);
      idle();
      check("t4_empty", 32'(last_empty), 32'd1);

      // Fill to full, stall once, retry succeeds
      for (int i = 0; i < WB_DEPTH; i++) begin
         cycle(1'b1, 1'b1, 32'h50 + 32'(i * 4), 4'hF, 32'hA000_0000 + 32'(i));
      end
      cycle(1'b1, 1'b0, 32'h60, 4'hF, 32'hA000_0004);
      check("t5_stall",      32'(last_stall), 32'd1);
      check("t5_drain_addr", last_addr,       32'h50);
      cycle(1'b1, 1'b0, 32'h60, 4'hF, 32'hA000_0004);
      check("t5_retry_stall", 32'(last_stall), 32'd0);
      drain_all("t5_drain_bound");
      for (int i = 0; i < 5; i++) begin
         check("t5_ram", ram[20 + i], 32'hA000_0000 + 32'(i));
      end

      // Wrap-around: 3*DEPTH distinct stores with random load gaps
      for (int i = 0; i < 3 * WB_DEPTH; i++) begin
         int tries;
         tries = 0;
         do begin
            cycle(1'b1, 1'b0, 32'h80 + 32'(i * 4), 4'hF, $urandom);
            tries++;
         end while (last_stall && tries < 4);
         check("t6_accept", 32'(last_stall), 32'd0);
         repeat ($urandom_range(0, 3)) begin
            cycle(1'b0, 1'b1, 32'($urandom_range(0, 63)) << 2, 4'hF, 32'h0);
         end
      end
      drain_all("t6_drain_bound");

      // Random mixed traffic over a small address window to exercise coalescing
      for (int n = 0; n < 300; n++) begin
         int r;
         r = int'($urandom_range(0, 3));
         if (r == 0) begin
            idle();
         end else if (r == 1) begin
            cycle(1'b0, 1'b1, 32'($urandom_range(0, 15)) << 2, 4'hF, 32'h0);
         end else begin
            cycle(1'b1, 1'b0, 32'($urandom_range(0, 15)) << 2,
                  4'($urandom_range(1, 15)), $urandom);
         end
      end
      drain_all("rand_drain_bound");

      for (int i = 0; i < 64; i++) begin
         check("ram_final", ram[i], ref_ram[i]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
